// File: rtl/rb_diag_interp_pipe.sv
// rtl/rb_diag_interp_pipe.sv - edge-directed R/B interpolation at diagonal sites, 3-stage pipe
module rb_diag_interp_pipe #(
   parameter int DW   = 10,
   parameter int SATW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4*DW-1:0] in_pix,
   input  logic [5*DW-1:0] in_g,
   input  logic [1:0]      in_mode,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_rb,
   output logic            out_sat,
   output logic [SATW-1:0] sat_cnt,
   input  logic            sat_clr
);

   localparam int W = DW + 3;
   typedef logic signed [W-1:0] sw_t;

   localparam sw_t MAXV = sw_t'({3'b000, {DW{1'b1}}});

   function automatic sw_t ext(input logic [DW-1:0] v);
      return sw_t'({3'b000, v});
   endfunction

   function automatic sw_t abs_s(input sw_t x);
      return (x < 0) ? -x : x;
   endfunction

   logic [DW-1:0] d33, d35, d53, d55, g44, g33, g35, g53, g55;
   assign d33 = in_pix[DW-1:0];
   assign d35 = in_pix[2*DW-1:DW];
   assign d53 = in_pix[3*DW-1:2*DW];
   assign d55 = in_pix[4*DW-1:3*DW];
   assign g44 = in_g[DW-1:0];
   assign g33 = in_g[2*DW-1:DW];
   assign g35 = in_g[3*DW-1:2*DW];
   assign g53 = in_g[4*DW-1:3*DW];
   assign g55 = in_g[5*DW-1:4*DW];

   // One global enable: the whole pipe freezes only when the output is blocked.
   logic advance;
   assign advance  = !(out_valid && !out_ready);
   assign in_ready = advance;

   sw_t d45_c, d135_c, c45_c, c135_c, cavg_c, cbil_c;
   always_comb begin
      d45_c  = abs_s(ext(d35) - ext(d53)) + abs_s((ext(g44) <<< 1) - ext(g35) - ext(g53));
      d135_c = abs_s(ext(d33) - ext(d55)) + abs_s((ext(g44) <<< 1) - ext(g33) - ext(g55));
      c45_c  = (ext(d35) >>> 1) + (ext(d53) >>> 1) + ext(g44)
               - (ext(g35) >>> 1) - (ext(g53) >>> 1);
      c135_c = (ext(d33) >>> 1) + (ext(d55) >>> 1) + ext(g44)
               - (ext(g33) >>> 1) - (ext(g55) >>> 1);
      cavg_c = (ext(d33) >>> 2) + (ext(d35) >>> 2) + (ext(d53) >>> 2) + (ext(d55) >>> 2)
               + ext(g44)
               - (ext(g33) >>> 2) - (ext(g35) >>> 2) - (ext(g53) >>> 2) - (ext(g55) >>> 2);
      cbil_c = (ext(d33) + ext(d35) + ext(d53) + ext(d55)) >>> 2;
   end

   logic       s1_valid, s2_valid;
   sw_t        s1_d45, s1_d135, s1_c45, s1_c135, s1_cavg, s1_cbil;
   logic [1:0] s1_mode;
   sw_t        s2_val;

   sw_t sel_c;
   always_comb begin
      sel_c = s1_cavg;
      case (s1_mode)
         2'd1:    sel_c = s1_cavg;
         2'd2:    sel_c = s1_cbil;
         default: begin
            if (s1_d45 < s1_d135)      sel_c = s1_c45;
            else if (s1_d45 > s1_d135) sel_c = s1_c135;
            else                       sel_c = s1_cavg;
         end
      endcase
   end

   logic [DW-1:0] clamp_c;
   logic          clamp_sat_c;
   always_comb begin
      clamp_c     = s2_val[DW-1:0];
      clamp_sat_c = 1'b0;
      if (s2_val < 0) begin
         clamp_c     = '0;
         clamp_sat_c = 1'b1;
      end else if (s2_val > MAXV) begin
         clamp_c     = '1;
         clamp_sat_c = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         out_rb    <= '0;
         out_sat   <= 1'b0;
      end else if (advance) begin
         s1_valid  <= in_valid;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
         if (s2_valid) begin
            out_rb  <= clamp_c;
            out_sat <= clamp_sat_c;
         end
      end
   end

   // Payload registers carry no reset; their valid bits qualify them.
   always_ff @(posedge clk) begin
      if (advance) begin
         s1_d45  <= d45_c;
         s1_d135 <= d135_c;
         s1_c45  <= c45_c;
         s1_c135 <= c135_c;
         s1_cavg <= cavg_c;
         s1_cbil <= cbil_c;
         s1_mode <= (in_mode == 2'd3) ? 2'd0 : in_mode;
         s2_val  <= sel_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sat_cnt <= '0;
      else if (sat_clr)
         sat_cnt <= '0;
      else if (out_valid && out_ready && out_sat && (sat_cnt != {SATW{1'b1}}))
         sat_cnt <= sat_cnt + SATW'(1);
   end

endmodule
